// File: rtl/nf10_upb_packet_length_annotator.sv
// nf10_upb_packet_length_annotator
//
// Store-and-forward stage placed directly ahead of the UPB output queue.
// Each AXI4-Stream packet is buffered in full while its bytes are counted
// from tkeep. The packet is then released with tuser.packet_length set on
// every beat, so the output queue knows the length before the first beat
// arrives.
//
// Storage:
//   data FIFO : {tdata, tkeep, tlast} per beat, data_fifo_depth entries
//   meta FIFO : {in_port, in_vport, out_port, out_vport, length} per packet
//
// A packet is visible on the egress side only after its tlast beat has been
// written. m_axis_tvalid is therefore simply "meta FIFO not empty".
//
// Optional feature (compile-time macro PKT_LEN_CHECK_EN):
//   Each counted length is compared against s_axis_tuser_packet_length as
//   sampled on the first beat. Mismatches are counted in len_mismatch_count,
//   which saturates at 0xFFFF. Without the macro, the count is tied to zero.

module nf10_upb_packet_length_annotator #(
   parameter int axis_data_width                = 256,
   parameter int axis_tkeep_width               = axis_data_width / 8,
   parameter int axis_tuser_in_port_width       = 3,
   parameter int axis_tuser_out_port_width      = 8,
   parameter int axis_tuser_packet_length_width = 14,
   parameter int data_fifo_depth                = 512,
   parameter int meta_fifo_depth                = 16
) (
   input  logic                                      clk,
   input  logic                                      reset,

   // ingress stream
   input  logic [axis_data_width-1:0]                s_axis_tdata,
   input  logic [axis_tkeep_width-1:0]               s_axis_tkeep,
   input  logic                                      s_axis_tlast,
   input  logic                                      s_axis_tvalid,
   output logic                                      s_axis_tready,
   input  logic [axis_tuser_in_port_width-1:0]       s_axis_tuser_in_port,
   input  logic [axis_tuser_in_port_width-1:0]       s_axis_tuser_in_vport,
   input  logic [axis_tuser_out_port_width-1:0]      s_axis_tuser_out_port,
   input  logic [axis_tuser_out_port_width-1:0]      s_axis_tuser_out_vport,
   input  logic [axis_tuser_packet_length_width-1:0] s_axis_tuser_packet_length,

   // egress stream towards the output queue
   output logic [axis_data_width-1:0]                m_axis_tdata,
   output logic [axis_tkeep_width-1:0]               m_axis_tkeep,
   output logic                                      m_axis_tlast,
   output logic                                      m_axis_tvalid,
   input  logic                                      m_axis_tready,
   output logic [axis_tuser_in_port_width-1:0]       m_axis_tuser_in_port,
   output logic [axis_tuser_in_port_width-1:0]       m_axis_tuser_in_vport,
   output logic [axis_tuser_out_port_width-1:0]      m_axis_tuser_out_port,
   output logic [axis_tuser_out_port_width-1:0]      m_axis_tuser_out_vport,
   output logic [axis_tuser_packet_length_width-1:0] m_axis_tuser_packet_length,

   output logic [15:0]                               len_mismatch_count
);

   // ------------------------------------------------------------------
   // Derived widths
   // ------------------------------------------------------------------
   localparam int KCW = $clog2(axis_tkeep_width + 1);          // bytes per beat
   localparam int LW  = axis_tuser_packet_length_width;         // length field
   localparam int LSW = LW + 1;                                 // length + carry
   localparam int DFW = axis_data_width + axis_tkeep_width + 1; // data FIFO word
   localparam int DAW = $clog2(data_fifo_depth);
   localparam int DCW = DAW + 1;
   localparam int MAW = $clog2(meta_fifo_depth);
   localparam int MCW = MAW + 1;

   localparam logic [LW-1:0]  LEN_MAX       = '1;
   localparam logic [DCW-1:0] DATA_FULL_CNT = DCW'(data_fifo_depth);
   localparam logic [MCW-1:0] META_FULL_CNT = MCW'(meta_fifo_depth);

   // ------------------------------------------------------------------
   // Packet metadata records
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [axis_tuser_in_port_width-1:0]  in_port;
      logic [axis_tuser_in_port_width-1:0]  in_vport;
      logic [axis_tuser_out_port_width-1:0] out_port;
      logic [axis_tuser_out_port_width-1:0] out_vport;
   } ports_t;

   typedef struct packed {
      ports_t          ports;
      logic [LW-1:0]   length;
   } meta_t;

   // Number of set bits in a tkeep word; holes in tkeep are simply counted.
   function automatic logic [KCW-1:0] popcount(input logic [axis_tkeep_width-1:0] keep);
      logic [KCW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < axis_tkeep_width; i++) begin
         cnt = cnt + KCW'(keep[i]);
      end
      return cnt;
   endfunction

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   // ingress side
   logic           in_hs;
   logic           sop;          // next accepted beat is the first of a packet
   logic [LW-1:0]  byte_count;
   logic [KCW-1:0] beat_bytes;
   logic [LSW-1:0] len_sum;
   logic [LW-1:0]  len_next;
   ports_t         in_ports;
   ports_t         cap_ports;
   ports_t         pkt_ports;

   // data FIFO
   logic [DFW-1:0] data_mem [data_fifo_depth];
   logic [DAW-1:0] data_wr_ptr;
   logic [DAW-1:0] data_rd_ptr;
   logic [DCW-1:0] data_count;
   logic           data_full;
   logic           data_push;
   logic           data_pop;
   logic           head_last;

   // meta FIFO
   meta_t          meta_mem [meta_fifo_depth];
   logic [MAW-1:0] meta_wr_ptr;
   logic [MAW-1:0] meta_rd_ptr;
   logic [MCW-1:0] meta_count;
   logic           meta_full;
   logic           meta_empty;
   logic           meta_push;
   logic           meta_pop;
   meta_t          meta_wdata;
   meta_t          meta_head;

   // ------------------------------------------------------------------
   // Ingress handshake and byte counting
   // ------------------------------------------------------------------
   assign data_full  = (data_count == DATA_FULL_CNT);
   assign meta_full  = (meta_count == META_FULL_CNT);
   assign meta_empty = (meta_count == '0);

   // The tlast beat must wait for a free meta slot. Full flags come from
   // registered occupancy, so there is no path from m_axis_tready.
   assign s_axis_tready = !reset && !data_full && !(meta_full && s_axis_tlast);

   assign in_hs     = s_axis_tvalid && s_axis_tready;
   assign data_push = in_hs;
   assign meta_push = in_hs && s_axis_tlast;

   assign beat_bytes = popcount(s_axis_tkeep);
   assign len_sum    = {1'b0, byte_count} + LSW'(beat_bytes);
   assign len_next   = len_sum[LW] ? LEN_MAX : len_sum[LW-1:0];

   assign in_ports = '{in_port:   s_axis_tuser_in_port,
                       in_vport:  s_axis_tuser_in_vport,
                       out_port:  s_axis_tuser_out_port,
                       out_vport: s_axis_tuser_out_vport};

   // A single-beat packet carries its ports on the beat being pushed, so
   // the live inputs are used while the capture register is not yet valid.
   assign pkt_ports  = sop ? in_ports : cap_ports;
   assign meta_wdata = '{ports: pkt_ports, length: len_next};

   // Track packet boundaries, accumulate the byte count and capture first-beat ports.
   // NOTE: state registers use non-blocking assignments only, so every
   // always_ff reads the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (reset) begin
         sop        <= 1'b1;
         byte_count <= '0;
         cap_ports  <= '0;
      end else if (in_hs) begin
         if (sop) begin
            cap_ports <= in_ports;
         end
         if (s_axis_tlast) begin
            sop        <= 1'b1;
            byte_count <= '0;
         end else begin
            sop        <= 1'b0;
            byte_count <= len_next;
         end
      end
   end

   // ------------------------------------------------------------------
   // Data FIFO
   // ------------------------------------------------------------------
   // Write beats into data storage.
   // NOTE: the storage arrays are deliberately not reset; the pointers and
   // occupancy counts alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (data_push) begin
         data_mem[data_wr_ptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
      end
   end

   // Advance data pointers and occupancy; a simultaneous push and pop keeps the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_wr_ptr <= '0;
         data_rd_ptr <= '0;
         data_count  <= '0;
      end else begin
         if (data_push) data_wr_ptr <= data_wr_ptr + DAW'(1);
         if (data_pop)  data_rd_ptr <= data_rd_ptr + DAW'(1);
         case ({data_push, data_pop})
            2'b10:   data_count <= data_count + DCW'(1);
            2'b01:   data_count <= data_count - DCW'(1);
            default: data_count <= data_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Meta FIFO
   // ------------------------------------------------------------------
   // Write one metadata record per completed packet.
   always_ff @(posedge clk) begin
      if (meta_push) begin
         meta_mem[meta_wr_ptr] <= meta_wdata;
      end
   end

   // Advance meta pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_wr_ptr <= '0;
         meta_rd_ptr <= '0;
         meta_count  <= '0;
      end else begin
         if (meta_push) meta_wr_ptr <= meta_wr_ptr + MAW'(1);
         if (meta_pop)  meta_rd_ptr <= meta_rd_ptr + MAW'(1);
         case ({meta_push, meta_pop})
            2'b10:   meta_count <= meta_count + MCW'(1);
            2'b01:   meta_count <= meta_count - MCW'(1);
            default: meta_count <= meta_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Egress
   // ------------------------------------------------------------------
   // A meta entry exists only for fully stored packets, so every beat of the
   // head packet is already in the data FIFO when tvalid rises.
   assign m_axis_tvalid = !meta_empty;
   assign data_pop      = m_axis_tvalid && m_axis_tready;
   assign meta_pop      = data_pop && head_last;

   assign {m_axis_tdata, m_axis_tkeep, head_last} = data_mem[data_rd_ptr];
   assign m_axis_tlast = head_last && m_axis_tvalid;

   assign meta_head                  = meta_mem[meta_rd_ptr];
   assign m_axis_tuser_in_port       = meta_head.ports.in_port;
   assign m_axis_tuser_in_vport      = meta_head.ports.in_vport;
   assign m_axis_tuser_out_port      = meta_head.ports.out_port;
   assign m_axis_tuser_out_vport     = meta_head.ports.out_vport;
   assign m_axis_tuser_packet_length = meta_head.length;

   // ------------------------------------------------------------------
   // Optional declared-length check
   // ------------------------------------------------------------------
`ifdef PKT_LEN_CHECK_EN
   logic [LW-1:0] cap_pkt_len;
   logic [LW-1:0] declared_len;
   logic [15:0]   mismatch_cnt;

   assign declared_len = sop ? s_axis_tuser_packet_length : cap_pkt_len;

   // Compare counted and declared lengths at each packet end; count saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_pkt_len  <= '0;
         mismatch_cnt <= '0;
      end else if (in_hs) begin
         if (sop) begin
            cap_pkt_len <= s_axis_tuser_packet_length;
         end
         if (s_axis_tlast && (len_next != declared_len) && (mismatch_cnt != 16'hFFFF)) begin
            mismatch_cnt <= mismatch_cnt + 16'd1;
         end
      end
   end

   assign len_mismatch_count = mismatch_cnt;
`else
   // The declared length is not used in this build.
   logic unused_pkt_len;
   assign unused_pkt_len     = ^s_axis_tuser_packet_length;
   assign len_mismatch_count = '0;
`endif

   // ------------------------------------------------------------------
   // Oversize-packet detection
   // ------------------------------------------------------------------
   // A full data FIFO with no complete packet inside can never drain: the
   // current packet is longer than the buffer and the stage is deadlocked.
   a_no_oversize_packet : assert property (
      @(posedge clk) disable iff (reset) !(data_full && meta_empty))
      else $error("packet longer than data_fifo_depth: stage deadlocked");

endmodule

// File: tb/tb_nf10_upb_packet_length_annotator.sv
// tb_nf10_upb_packet_length_annotator
// Self-checking bench for the packet length annotator. Expected egress beats
// are queued in order; the egress monitor compares every beat, including
// tuser, against the head of that queue. The bench honours the
// PKT_LEN_CHECK_EN macro in the same way as the design.

`timescale 1ns/1ps

module tb_nf10_upb_packet_length_annotator;

   logic          clk = 1'b0;
   logic          reset;
   logic [255:0]  s_axis_tdata;
   logic [31:0]   s_axis_tkeep;
   logic          s_axis_tlast;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [2:0]    s_axis_tuser_in_port;
   logic [2:0]    s_axis_tuser_in_vport;
   logic [7:0]    s_axis_tuser_out_port;
   logic [7:0]    s_axis_tuser_out_vport;
   logic [13:0]   s_axis_tuser_packet_length;
   logic [255:0]  m_axis_tdata;
   logic [31:0]   m_axis_tkeep;
   logic          m_axis_tlast;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [2:0]    m_axis_tuser_in_port;
   logic [2:0]    m_axis_tuser_in_vport;
   logic [7:0]    m_axis_tuser_out_port;
   logic [7:0]    m_axis_tuser_out_vport;
   logic [13:0]   m_axis_tuser_packet_length;
   logic [15:0]   len_mismatch_count;

   always #5 clk = ~clk;

   nf10_upb_packet_length_annotator dut (
      .clk                        (clk),
      .reset                      (reset),
      .s_axis_tdata               (s_axis_tdata),
      .s_axis_tkeep               (s_axis_tkeep),
      .s_axis_tlast               (s_axis_tlast),
      .s_axis_tvalid              (s_axis_tvalid),
      .s_axis_tready              (s_axis_tready),
      .s_axis_tuser_in_port       (s_axis_tuser_in_port),
      .s_axis_tuser_in_vport      (s_axis_tuser_in_vport),
      .s_axis_tuser_out_port      (s_axis_tuser_out_port),
      .s_axis_tuser_out_vport     (s_axis_tuser_out_vport),
      .s_axis_tuser_packet_length (s_axis_tuser_packet_length),
      .m_axis_tdata               (m_axis_tdata),
      .m_axis_tkeep               (m_axis_tkeep),
      .m_axis_tlast               (m_axis_tlast),
      .m_axis_tvalid              (m_axis_tvalid),
      .m_axis_tready              (m_axis_tready),
      .m_axis_tuser_in_port       (m_axis_tuser_in_port),
      .m_axis_tuser_in_vport      (m_axis_tuser_in_vport),
      .m_axis_tuser_out_port      (m_axis_tuser_out_port),
      .m_axis_tuser_out_vport     (m_axis_tuser_out_vport),
      .m_axis_tuser_packet_length (m_axis_tuser_packet_length),
      .len_mismatch_count         (len_mismatch_count)
   );

   // ------------------------------------------------------------------
   // Bench state
   // ------------------------------------------------------------------
   typedef struct {
      logic [255:0] data;
      logic [31:0]  keep;
      logic         last;
      logic [2:0]   ip;
      logic [2:0]   ivp;
      logic [7:0]   op;
      logic [7:0]   ovp;
      logic [13:0]  len;
   } beat_t;

   typedef struct {
      int               nbeats;
      logic [2:0][31:0] keep;     // keep[0] is the first beat
      logic [13:0]      exp_len;
      logic [2:0]       ip;
      logic [2:0]       ivp;
      logic [7:0]       op;
      logic [7:0]       ovp;
   } vec_t;

   beat_t        exp_q [$];
   logic [255:0] cur_data [$];
   logic [31:0]  cur_keep [$];
   int           n_vec = 0;
   int           n_err = 0;
   int           rdy_mode = 0;    // 0: tready low, 1: tready high, 2: random

   task automatic check(input string name, input logic [399:0] act, input logic [399:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [399:0] pack(input beat_t b);
      return 400'({b.data, b.keep, b.last, b.ip, b.ivp, b.op, b.ovp, b.len});
   endfunction

   function automatic logic [255:0] rand_data();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Reference length: total kept bytes, clipped to the 14-bit maximum.
   function automatic logic [13:0] model_len();
      int total = 0;
      foreach (cur_keep[i]) total += $countones(cur_keep[i]);
      return (total > 16383) ? 14'd16383 : 14'(total);
   endfunction

   task automatic new_pkt(input int n);
      cur_data.delete();
      cur_keep.delete();
      for (int i = 0; i < n; i++) begin
         cur_data.push_back(rand_data());
         cur_keep.push_back(32'hFFFF_FFFF);
      end
   endtask

   // Hold the current beat valid until accepted, bounded.
   task automatic wait_accept(output bit ok);
      s_axis_tvalid = 1'b1;
      ok = 1'b0;
      for (int w = 0; w < 3000 && !ok; w++) begin
         @(negedge clk);
         ok = s_axis_tready;
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
   endtask

   // Send cur_data/cur_keep; later beats carry garbage tuser to prove the
   // first-beat capture. Only beats [0, stop_after) are sent.
   task automatic send_pkt(input logic [2:0] ip, input logic [2:0] ivp,
                           input logic [7:0] op, input logic [7:0] ovp,
                           input logic [13:0] plen, input logic [13:0] exp_len,
                           input bit push_exp, input int stop_after, input int gap_pct);
      int n = cur_keep.size();
      bit ok;
      if (push_exp) begin
         for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data = cur_data[i];
            b.keep = cur_keep[i];
            b.last = (i == n - 1);
            b.ip   = ip;
            b.ivp  = ivp;
            b.op   = op;
            b.ovp  = ovp;
            b.len  = exp_len;
            exp_q.push_back(b);
         end
      end
      for (int i = 0; i < n && i < stop_after; i++) begin
         while ($urandom_range(99) < gap_pct) begin
            @(posedge clk);
            #1;
         end
         s_axis_tdata  = cur_data[i];
         s_axis_tkeep  = cur_keep[i];
         s_axis_tlast  = (i == n - 1);
         if (i == 0) begin
            s_axis_tuser_in_port       = ip;
            s_axis_tuser_in_vport      = ivp;
            s_axis_tuser_out_port      = op;
            s_axis_tuser_out_vport     = ovp;
            s_axis_tuser_packet_length = plen;
         end else begin
            s_axis_tuser_in_port       = 3'($urandom);
            s_axis_tuser_in_vport      = 3'($urandom);
            s_axis_tuser_out_port      = 8'($urandom);
            s_axis_tuser_out_vport     = 8'($urandom);
            s_axis_tuser_packet_length = 14'($urandom);
         end
         wait_accept(ok);
         if (!ok) begin
            check("ingress_timeout", 400'(s_axis_tready), 400'(1));
            return;
         end
      end
   endtask

   // Wait (bounded) until every expected beat has been seen.
   task automatic wait_drain(input int budget);
      int w = 0;
      while (exp_q.size() != 0 && w < budget) begin
         @(posedge clk);
         w++;
      end
      check("drain_left", 400'(exp_q.size()), 400'(0));
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Egress monitor and scoreboard
   // ------------------------------------------------------------------
   initial begin : monitor
      beat_t act;
      beat_t exp_b;
      m_axis_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = ($urandom_range(99) < 60);
         endcase
         @(negedge clk);
         if (m_axis_tvalid && m_axis_tready) begin
            act.data = m_axis_tdata;
            act.keep = m_axis_tkeep;
            act.last = m_axis_tlast;
            act.ip   = m_axis_tuser_in_port;
            act.ivp  = m_axis_tuser_in_vport;
            act.op   = m_axis_tuser_out_port;
            act.ovp  = m_axis_tuser_out_vport;
            act.len  = m_axis_tuser_packet_length;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 400'(m_axis_tvalid), 400'(0));
            end else begin
               exp_b = exp_q.pop_front();
               check("beat", pack(act), pack(exp_b));
            end
         end
      end
   end

   // Hang guard.
   initial begin
      #800us;
      $display("FAIL watchdog: simulation did not finish, %0d expected beats left", exp_q.size());
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin : main
      vec_t tbl [8];
      logic stale;
      logic [13:0] len;
      int n;
      int r;

      tbl[0] = '{2, {32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF}, 14'd64, 3'd1, 3'd2, 8'h04, 8'h10};
      tbl[1] = '{3, {32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 14'd65, 3'd3, 3'd4, 8'h01, 8'h02};
      tbl[2] = '{2, {32'h0,         32'h0000_FFFF, 32'h0000_FFFF}, 14'd32, 3'd5, 3'd6, 8'h80, 8'h40};
      tbl[3] = '{1, {32'h0,         32'h0,         32'hFFFF_FFFF}, 14'd32, 3'd7, 3'd0, 8'hFF, 8'h01};
      tbl[4] = '{1, {32'h0,         32'h0,         32'hAAAA_AAAA}, 14'd16, 3'd0, 3'd7, 8'h11, 8'h22};
      tbl[5] = '{3, {32'h8000_0001, 32'h0,         32'hF0F0_F0F0}, 14'd18, 3'd2, 3'd5, 8'h33, 8'h44};
      tbl[6] = '{1, {32'h0,         32'h0,         32'h0},         14'd0,  3'd6, 3'd1, 8'h55, 8'hAA};
      tbl[7] = '{2, {32'h0,         32'h0000_0001, 32'h0000_0001}, 14'd2,  3'd4, 3'd3, 8'h66, 8'h99};

      reset                      = 1'b1;
      s_axis_tdata               = '0;
      s_axis_tkeep               = '0;
      s_axis_tlast               = 1'b0;
      s_axis_tvalid              = 1'b0;
      s_axis_tuser_in_port       = '0;
      s_axis_tuser_in_vport      = '0;
      s_axis_tuser_out_port      = '0;
      s_axis_tuser_out_vport     = '0;
      s_axis_tuser_packet_length = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_tready",   400'(s_axis_tready),      400'(0));
      check("rst_m_tvalid",   400'(m_axis_tvalid),      400'(0));
      check("rst_m_tlast",    400'(m_axis_tlast),       400'(0));
      check("rst_mismatches", 400'(len_mismatch_count), 400'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // No cut-through: tvalid is still low while the tlast handshake happens
      rdy_mode = 1;
      new_pkt(1);
      fork
         send_pkt(3'd1, 3'd1, 8'h01, 8'h01, 14'd32, 14'd32, 1'b1, 1, 0);
         begin
            @(negedge clk);
            check("no_cut_through", 400'(m_axis_tvalid), 400'(0));
         end
      join
      wait_drain(100);

      // Table-driven packets
      for (int v = 0; v < 8; v++) begin
         new_pkt(tbl[v].nbeats);
         for (int b = 0; b < tbl[v].nbeats; b++) cur_keep[b] = tbl[v].keep[b];
         send_pkt(tbl[v].ip, tbl[v].ivp, tbl[v].op, tbl[v].ovp,
                  tbl[v].exp_len, tbl[v].exp_len, 1'b1, tbl[v].nbeats, 0);
      end
      wait_drain(300);

      // Meta FIFO full: 16 packets held, the 17th tlast stalls
      rdy_mode = 0;
      for (int k = 0; k < 16; k++) begin
         new_pkt(1);
         send_pkt(3'(k), 3'(k + 1), 8'(k), 8'(255 - k), 14'd32, 14'd32, 1'b1, 1, 0);
      end
      new_pkt(1);
      fork
         send_pkt(3'd0, 3'd7, 8'hA5, 8'h5A, 14'd32, 14'd32, 1'b1, 1, 0);
         begin
            repeat (4) @(negedge clk);
            check("stall_s_tready", 400'(s_axis_tready), 400'(0));
            check("stall_m_tvalid", 400'(m_axis_tvalid), 400'(1));
            rdy_mode = 1;
         end
      join
      wait_drain(500);

      // Reset in the middle of a 10-beat packet
      rdy_mode = 1;
      new_pkt(10);
      send_pkt(3'd4, 3'd4, 8'h0F, 8'hF0, 14'd320, 14'd320, 1'b0, 5, 0);
      check("partial_not_released", 400'(m_axis_tvalid), 400'(0));
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_s_tready", 400'(s_axis_tready), 400'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      stale = 1'b0;
      repeat (10) begin
         @(negedge clk);
         stale = stale | m_axis_tvalid;
      end
      @(posedge clk);
      #1;
      check("no_stale_beat", 400'(stale), 400'(0));
      new_pkt(2);
      send_pkt(3'd2, 3'd3, 8'h12, 8'h34, 14'd64, 14'd64, 1'b1, 2, 0);
      wait_drain(100);

      // Randomized traffic against the reference length model
      rdy_mode = 2;
      for (int p = 0; p < 300; p++) begin
         n = ($urandom_range(9) == 0) ? $urandom_range(300, 1) : $urandom_range(6, 1);
         new_pkt(n);
         for (int b = 0; b < n; b++) begin
            r = $urandom_range(9);
            if (r < 6)       cur_keep[b] = 32'hFFFF_FFFF;
            else if (r < 8)  cur_keep[b] = $urandom;
            else if (r == 8) cur_keep[b] = 32'hFFFF_FFFF >> $urandom_range(31);
            else             cur_keep[b] = 32'h0;
         end
         len = model_len();
         send_pkt(3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
                  len, len, 1'b1, n, 25);
      end
      wait_drain(20000);

`ifdef PKT_LEN_CHECK_EN
      // Declared 100 bytes, actually 96: counted and forwarded length is 96
      rdy_mode = 1;
      new_pkt(3);
      send_pkt(3'd5, 3'd2, 8'h77, 8'h88, 14'd100, 14'd96, 1'b1, 3, 0);
      wait_drain(100);
      check("len_mismatch_count", 400'(len_mismatch_count), 400'(1));
`else
      check("len_mismatch_count", 400'(len_mismatch_count), 400'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
